// File: rtl/raytrace_pkg.sv
// raytrace_pkg: shared widths, sentinels and collector state encoding
package raytrace_pkg;
  localparam int Q_BITS = 10;
  localparam int D_BITS = 32;
  localparam int M_BITS = 12;
  localparam int TRI_COUNT = 12;
  localparam logic signed [D_BITS-1:0] T_MAX = {1'b0, {(D_BITS-1){1'b1}}};
  localparam logic [M_BITS-1:0] IDX_NONE = '1;
  localparam logic [M_BITS-1:0] LAST_IDX = M_BITS'(TRI_COUNT - 1);
  typedef enum logic [1:0] {WAIT, POP, EMIT} state_t;
endpackage

// File: rtl/closest_hit_cmp.sv
// closest_hit_cmp: decides whether the current record replaces the best hit so far
// cur_hit/cur_t: record under test; best_hit/best_t: running best; take_new: replace best
module closest_hit_cmp
  import raytrace_pkg::*;
(
  input  logic                     cur_hit,
  input  logic signed [D_BITS-1:0] cur_t,
  input  logic                     best_hit,
  input  logic signed [D_BITS-1:0] best_t,
  output logic                     take_new
);
  // t must be strictly positive; strict less-than keeps the lower index on ties
  assign take_new = cur_hit && !cur_t[D_BITS-1] && cur_t != '0 && (!best_hit || cur_t < best_t);
endmodule

// File: rtl/hit_collector.sv
// hit_collector: reduces TRI_COUNT hit records per ray to one closest-hit result
// clock/reset: sync active-high; in_*/hit_in/t_in: FWFT hit FIFO; out_*/result_*: result FIFO write side
module hit_collector
  import raytrace_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_empty,
  output logic                     in_rd_en,
  input  logic                     hit_in,
  input  logic signed [D_BITS-1:0] t_in,
  input  logic                     out_full,
  output logic                     out_wr_en,
  output logic                     result_hit,
  output logic [M_BITS-1:0]        result_idx,
  output logic signed [D_BITS-1:0] result_t
);
  state_t                     state_q;
  logic [M_BITS-1:0]          tri_cnt_q;
  logic                       best_hit_q;
  logic [M_BITS-1:0]          best_idx_q;
  logic signed [D_BITS-1:0]   best_t_q;
  logic                       cur_hit_q;
  logic signed [D_BITS-1:0]   cur_t_q;
  logic                       take_new;
  closest_hit_cmp u_cmp (
    .cur_hit  (cur_hit_q),
    .cur_t    (cur_t_q),
    .best_hit (best_hit_q),
    .best_t   (best_t_q),
    .take_new (take_new)
  );
  always_ff @(posedge clock) begin
    if (reset || !(state_q inside {WAIT, POP, EMIT})) begin
      state_q    <= WAIT;
      in_rd_en   <= 1'b0;
      out_wr_en  <= 1'b0;
      result_hit <= 1'b0;
      result_idx <= IDX_NONE;
      result_t   <= T_MAX;
      tri_cnt_q  <= '0;
      best_hit_q <= 1'b0;
      best_idx_q <= IDX_NONE;
      best_t_q   <= T_MAX;
      cur_hit_q  <= 1'b0;
      cur_t_q    <= '0;
    end else begin
      case (state_q)
        WAIT: begin
          out_wr_en <= 1'b0;
          if (!in_empty) begin
            cur_hit_q <= hit_in;
            cur_t_q   <= t_in;
            in_rd_en  <= 1'b1;
            state_q   <= POP;
          end
        end
        POP: begin
          in_rd_en <= 1'b0;
          if (take_new) begin
            best_hit_q <= 1'b1;
            best_t_q   <= cur_t_q;
            best_idx_q <= tri_cnt_q;
          end
          if (tri_cnt_q == LAST_IDX) begin
            state_q <= EMIT;
          end else begin
            tri_cnt_q <= tri_cnt_q + M_BITS'(1);
            state_q   <= WAIT;
          end
        end
        default: begin
          out_wr_en <= !out_full;
          if (!out_full) begin
            result_hit <= best_hit_q;
            result_idx <= best_idx_q;
            result_t   <= best_t_q;
            tri_cnt_q  <= '0;
            best_hit_q <= 1'b0;
            best_idx_q <= IDX_NONE;
            best_t_q   <= T_MAX;
            state_q    <= WAIT;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hit_collector.sv
// tb_hit_collector: randomized and directed self-checking bench for hit_collector
module tb_hit_collector;
  import raytrace_pkg::*;
  typedef struct {logic hit; logic signed [31:0] t;} rec_t;
  typedef struct {logic hit; logic [11:0] idx; logic signed [31:0] t;} res_t;
  logic clock = 0, reset = 1, in_empty = 1, hit_in = 0, out_full = 0;
  logic signed [31:0] t_in = 0;
  logic in_rd_en, out_wr_en, result_hit;
  logic [11:0] result_idx;
  logic signed [31:0] result_t;
  rec_t fifo_q[$];
  res_t exp_q[$];
  rec_t ray[12];
  int n_checks = 0, n_pass = 0, pops = 0, writes = 0;
  bit gap_en = 0;
  hit_collector dut (
    .clock      (clock),
    .reset      (reset),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .hit_in     (hit_in),
    .t_in       (t_in),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .result_hit (result_hit),
    .result_idx (result_idx),
    .result_t   (result_t)
  );
  always #5 clock = ~clock;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic push_ray();
    logic signed [31:0] ts[$];
    logic signed [31:0] m;
    res_t r;
    r.hit = 0; r.idx = 12'hFFF; r.t = 32'h7FFFFFFF;
    foreach (ray[i]) begin
      fifo_q.push_back(ray[i]);
      if (ray[i].hit && ray[i].t > 0) ts.push_back(ray[i].t);
    end
    if (ts.size() != 0) begin
      m = ts.min()[0];
      r.hit = 1; r.t = m;
      for (int i = 11; i >= 0; i--)
        if (ray[i].hit && ray[i].t == m) r.idx = 12'(i);
    end
    exp_q.push_back(r);
  endtask
  task automatic clear_ray();
    foreach (ray[i]) begin ray[i].hit = 0; ray[i].t = $urandom; end
  endtask
  task automatic rand_ray();
    int v;
    foreach (ray[i]) begin
      v = $urandom_range(0, 40);
      ray[i].hit = 1'($urandom_range(0, 1));
      ray[i].t = v - 8;
    end
  endtask
  task automatic wait_pops(int target);
    int n = 0;
    while (pops < target && n < 3000) begin @(negedge clock); n++; end
    check("pops_reached", pops >= target, 1);
  endtask
  task automatic wait_writes(int target);
    int n = 0;
    while (writes < target && n < 3000) begin @(negedge clock); n++; end
    check("writes_reached", writes >= target, 1);
  endtask
  initial begin
    bit rd;
    forever begin
      @(negedge clock);
      rd = in_rd_en;
      @(posedge clock);
      #1;
      if (rd) begin
        check("pop_has_data", fifo_q.size() != 0, 1);
        if (fifo_q.size() != 0) fifo_q.delete(0);
        pops++;
      end
      in_empty = fifo_q.size() == 0 || (gap_en && $urandom_range(0, 2) == 0);
      if (fifo_q.size() != 0) begin hit_in = fifo_q[0].hit; t_in = fifo_q[0].t; end
      else begin hit_in = 1'($urandom); t_in = $urandom; end
    end
  end
  initial begin
    bit prev;
    res_t e;
    prev = 0;
    forever begin
      @(negedge clock);
      if (in_rd_en) check("rd_not_consecutive", prev, 0);
      prev = in_rd_en;
      if (out_wr_en) begin
        writes++;
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_hit", result_hit, e.hit);
          check("res_idx", result_idx, e.idx);
          check("res_t", result_t, e.t);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    int p, w;
    repeat (3) @(negedge clock);
    check("rst_rd_en", in_rd_en, 0);
    check("rst_wr_en", out_wr_en, 0);
    check("rst_hit", result_hit, 0);
    check("rst_idx", result_idx, 12'hFFF);
    check("rst_t", result_t, 32'h7FFFFFFF);
    reset = 0;
    clear_ray();
    ray[3] = '{1, 32'h500};
    ray[7] = '{1, 32'h200};
    p = pops; w = writes;
    push_ray();
    wait_pops(p + 12);
    check("emit_not_early", out_wr_en, 0);
    @(negedge clock);
    check("emit_latency", out_wr_en, 1);
    wait_writes(w + 1);
    clear_ray();
    w = writes;
    push_ray();
    wait_writes(w + 1);
    clear_ray();
    ray[2] = '{1, 32'h100};
    ray[9] = '{1, 32'h100};
    ray[5] = '{1, -32'sh40};
    ray[6] = '{1, 32'h0};
    w = writes;
    push_ray();
    wait_writes(w + 1);
    clear_ray();
    ray[11] = '{1, 32'h10};
    out_full = 1;
    p = pops; w = writes;
    push_ray();
    wait_pops(p + 12);
    repeat (5) begin
      @(negedge clock);
      check("stall_no_write", out_wr_en, 0);
      check("stall_no_pop", in_rd_en, 0);
    end
    out_full = 0;
    @(negedge clock);
    check("stall_release_write", out_wr_en, 1);
    wait_writes(w + 1);
    @(negedge clock);
    check("single_write", writes - w, 1);
    gap_en = 1;
    p = pops; w = writes;
    repeat (3) begin rand_ray(); push_ray(); end
    wait_writes(w + 3);
    wait_pops(p + 36);
    repeat (4) @(negedge clock);
    check("three_ray_writes", writes - w, 3);
    check("three_ray_pops", pops - p, 36);
    foreach (ray[i]) ray[i] = '{1, 32'h300 + i};
    ray[1] = '{1, 32'h20};
    p = pops;
    push_ray();
    wait_pops(p + 6);
    reset = 1;
    fifo_q.delete();
    exp_q.delete();
    w = writes;
    repeat (2) @(negedge clock);
    check("midrst_idx", result_idx, 12'hFFF);
    check("midrst_t", result_t, 32'h7FFFFFFF);
    check("midrst_wr", out_wr_en, 0);
    reset = 0;
    foreach (ray[i]) ray[i] = '{1, 32'h300 + i};
    ray[4] = '{1, 32'h50};
    push_ray();
    wait_writes(w + 1);
    check("midrst_one_write", writes - w, 1);
    w = writes;
    repeat (15) begin rand_ray(); push_ray(); end
    wait_writes(w + 15);
    repeat (4) @(negedge clock);
    check("all_results_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
